// File: rtl/game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | game_pkg : shared game state encodings and hold-timer defaults      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } game_state_t;

  localparam int unsigned c_HOLD_CYCLES = 200000000;
  localparam int unsigned c_HOLD_WIDTH  = 28;

  function automatic logic is_hold_state(input game_state_t s);
    return (s == ST_WIN) || (s == ST_LOSE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rising_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rising_edge_detect : one-cycle pulse when IN is high after a low    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rising_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic IN,
  output logic PULSE
);

  logic r_in_prev;

  // History resets high so a level already asserted at reset release is not an edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_in_prev <= 1'b1;
    end else begin
      r_in_prev <= IN;
    end
  end

  assign PULSE = IN & ~r_in_prev;

endmodule
`default_nettype wire

// File: rtl/game_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | game_controller : IDLE/PLAY/WIN/LOSE sequencer with hold timer      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = c_HOLD_CYCLES,
  parameter int unsigned HOLD_WIDTH  = c_HOLD_WIDTH
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_START,
  input  logic       APPLE_EATEN,
  input  logic       COLLISION,
  input  logic       FINISHED,
  output logic [1:0] STATE,
  output logic       SCORE_ENABLE,
  output logic       SCORE_RESET,
  output logic       SNAKE_RUN
);

  localparam logic [HOLD_WIDTH-1:0] c_HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);

  game_state_t           r_state;
  game_state_t           w_state_next;
  logic [HOLD_WIDTH-1:0] r_hold_timer;
  logic [HOLD_WIDTH-1:0] w_hold_timer_next;
  logic                  w_score_enable_next;
  logic                  w_start_pulse;
  logic                  w_apple_pulse;

  rising_edge_detect u_start_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .IN    (BTN_START),
    .PULSE (w_start_pulse)
  );

  rising_edge_detect u_apple_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .IN    (APPLE_EATEN),
    .PULSE (w_apple_pulse)
  );

  // Timer stays at 0 unless the next cycle is a continuing WIN/LOSE dwell.
  always_comb begin
    w_state_next        = r_state;
    w_hold_timer_next   = '0;
    w_score_enable_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_pulse) begin
          w_state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (COLLISION) begin
          w_state_next = ST_LOSE;
        end else if (FINISHED) begin
          w_state_next = ST_WIN;
        end else if (w_apple_pulse) begin
          w_score_enable_next = 1'b1;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (r_hold_timer == c_HOLD_LAST) begin
          w_state_next = ST_IDLE;
        end else begin
          w_hold_timer_next = r_hold_timer + 1'b1;
        end
      end
    endcase
  end

  // Status outputs are derived from the next state so they align with STATE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_hold_timer <= '0;
      SCORE_ENABLE <= 1'b0;
      SCORE_RESET  <= 1'b1;
      SNAKE_RUN    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_hold_timer <= w_hold_timer_next;
      SCORE_ENABLE <= w_score_enable_next;
      SCORE_RESET  <= (w_state_next == ST_IDLE);
      SNAKE_RUN    <= (w_state_next == ST_PLAY);
    end
  end

  assign STATE = r_state;

endmodule
`default_nettype wire
